// File: rtl/sgf_mult_core.sv
// Combinational unsigned WA x WB multiplier producing the full WA+WB bit product.
// Zero latency; no flow control.
module sgf_mult_core #(
  parameter int WA = 12,
  parameter int WB = 12
) (
  input  logic [WA-1:0]    a_i,
  input  logic [WB-1:0]    b_i,
  output logic [WA+WB-1:0] p_o
);

  assign p_o = (WA+WB)'(a_i) * (WA+WB)'(b_i);

endmodule

// File: rtl/sgf_multiplication.sv
// Registered SW x SW unsigned significand multiplier using one level of Karatsuba-Ofman.
// Two edges from operand presentation to sgf_result_o; one operand pair per cycle, no backpressure.
module sgf_multiplication #(
  parameter int SW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_a_i,
  input  logic            load_b_i,
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic [2*SW-1:0] sgf_result_o
);

  localparam int L  = SW / 2;
  localparam int H  = SW - L;
  localparam int PW = 2 * SW;
  localparam int SSW = H + 1;
  localparam int PSW = 2 * H + 2;

  logic [SW-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]  r_q, r_d;

  logic [H-1:0]   ah, bh;
  logic [L-1:0]   al, bl;
  logic [SSW-1:0] sa, sb;
  logic [2*H-1:0] ph;
  logic [2*L-1:0] pl;
  logic [PSW-1:0] ps, pm;

  always_comb begin
    a_d = load_a_i ? Data_A_i : a_q;
    b_d = load_b_i ? Data_B_i : b_q;
  end

  assign ah = a_q[SW-1:L];
  assign al = a_q[L-1:0];
  assign bh = b_q[SW-1:L];
  assign bl = b_q[L-1:0];

  // Low half is never wider than the high half, so H+1 bits hold either sum.
  assign sa = SSW'(ah) + SSW'(al);
  assign sb = SSW'(bh) + SSW'(bl);

  sgf_mult_core #(.WA(H),   .WB(H))   u_mul_h (.a_i(ah), .b_i(bh), .p_o(ph));
  sgf_mult_core #(.WA(L),   .WB(L))   u_mul_l (.a_i(al), .b_i(bl), .p_o(pl));
  sgf_mult_core #(.WA(SSW), .WB(SSW)) u_mul_s (.a_i(sa), .b_i(sb), .p_o(ps));

  assign pm = ps - PSW'(ph) - PSW'(pl);

  // Every term fits in PW bits, and the true product does too, so modulo-2^PW sums are exact.
  assign r_d = (PW'(ph) << (2 * L)) + (PW'(pm) << L) + PW'(pl);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
    end
  end

  assign sgf_result_o = r_q;

endmodule

// File: tb/tb_sgf_multiplication.sv
// Directed and random checks of sgf_multiplication at SW = 4, 5 and 24.
module tb_sgf_multiplication;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, la4, lb4;
  logic [3:0]  a4, b4;
  logic [7:0]  r4;
  logic        rst5, la5, lb5;
  logic [4:0]  a5, b5;
  logic [9:0]  r5;
  logic        rst24, la24, lb24;
  logic [23:0] a24, b24;
  logic [47:0] r24;

  sgf_multiplication #(.SW(4)) dut4 (
    .clk(clk), .rst(rst4), .load_a_i(la4), .load_b_i(lb4),
    .Data_A_i(a4), .Data_B_i(b4), .sgf_result_o(r4)
  );
  sgf_multiplication #(.SW(5)) dut5 (
    .clk(clk), .rst(rst5), .load_a_i(la5), .load_b_i(lb5),
    .Data_A_i(a5), .Data_B_i(b5), .sgf_result_o(r5)
  );
  sgf_multiplication #(.SW(24)) dut24 (
    .clk(clk), .rst(rst24), .load_a_i(la24), .load_b_i(lb24),
    .Data_A_i(a24), .Data_B_i(b24), .sgf_result_o(r24)
  );

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string tag);
    a4 = a; b4 = b; la4 = 1'b1; lb4 = 1'b1;
    tick();
    la4 = 1'b0; lb4 = 1'b0;
    tick();
    chk(tag, {40'd0, r4}, {40'd0, exp});
  endtask

  logic [9:0] exp5_prev;
  logic [4:0] ra, rb;

  initial begin
    rst4 = 1'b1; la4 = 1'b1; lb4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    rst5 = 1'b1; la5 = 1'b0; lb5 = 1'b0; a5 = '0; b5 = '0;
    rst24 = 1'b1; la24 = 1'b0; lb24 = 1'b0; a24 = '0; b24 = '0;
    exp5_prev = '0;

    // SW=4: reset held with loads active
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst4_hold", {40'd0, r4}, 48'd0);
    end
    chk("rst5_init", {38'd0, r5}, 48'd0);
    chk("rst24_init", r24, 48'd0);

    rst4 = 1'b0;
    tick();
    chk("rst4_release_edge1", {40'd0, r4}, 48'd0);
    tick();
    chk("rst4_release_edge2", {40'd0, r4}, 48'hE1);

    op4(4'b1010, 4'b0011, 8'h1E, "a10_b3");
    tick(); tick(); tick();
    chk("a10_b3_hold", {40'd0, r4}, 48'h1E);

    op4(4'd9, 4'd7, 8'h3F, "a9_b7");
    a4 = 4'd2; la4 = 1'b1;
    tick();
    la4 = 1'b0;
    tick();
    chk("load_a_only", {40'd0, r4}, 48'h0E);

    op4(4'd0, 4'd15, 8'h00, "zero");
    op4(4'd1, 4'd13, 8'h0D, "identity");

    // SW=5: odd split
    rst5 = 1'b0;
    a5 = 5'd31; b5 = 5'd31; la5 = 1'b1; lb5 = 1'b1;
    tick();
    la5 = 1'b0; lb5 = 1'b0;
    tick();
    chk("sw5_max", {38'd0, r5}, 48'h3C1);

    // SW=5: streaming random pairs, result of iteration i-1 visible after tick i
    for (int i = 0; i <= 1000; i++) begin
      if (i < 1000) begin
        ra = 5'($urandom_range(0, 31));
        rb = 5'($urandom_range(0, 31));
        a5 = ra; b5 = rb; la5 = 1'b1; lb5 = 1'b1;
      end else begin
        la5 = 1'b0; lb5 = 1'b0;
      end
      tick();
      if (i > 0) chk("sw5_rand", {38'd0, r5}, {38'd0, exp5_prev});
      exp5_prev = 10'(ra) * 10'(rb);
    end

    // SW=24: full-scale operands, then reset mid-stream
    rst24 = 1'b0;
    a24 = 24'hFFFFFF; b24 = 24'hFFFFFF; la24 = 1'b1; lb24 = 1'b1;
    tick();
    la24 = 1'b0; lb24 = 1'b0;
    tick();
    chk("sw24_max", r24, 48'hFFFFFE000001);

    a24 = 24'h123456; b24 = 24'h654321; la24 = 1'b1; lb24 = 1'b1;
    tick();
    rst24 = 1'b1;
    tick();
    chk("sw24_midrst", r24, 48'd0);
    rst24 = 1'b0; la24 = 1'b0; lb24 = 1'b0;
    tick();
    chk("sw24_after_rst", r24, 48'd0);
    tick();
    chk("sw24_after_rst2", r24, 48'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
